// File: rtl/mc_control_unit.sv
// Unified control sequencer for the shared 16-bit bus datapath: fetch, decode and
// execute of ALU/ALUi/LOAD/STORE/MOV/MOVi/JMP/BZ, with memory-wait timeout fault.
module mc_control_unit #(
    parameter int DATA_W      = 16,
    parameter int NREG        = 4,
    parameter int NPORT       = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [15:0]            ir,
    input  logic                   mfc,
    input  logic                   z_flag,
    output logic                   pc_out_en,
    output logic                   pc_inc,
    output logic                   pc_load,
    output logic                   mar_in,
    output logic                   mdr_write_en,
    output logic                   mdr_read_en,
    output logic                   mdr_out,
    output logic                   mem_en,
    output logic                   mem_rw,
    output logic                   ir_in,
    output logic                   alu_in0,
    output logic                   alu_in1,
    output logic                   alu_latch,
    output logic                   alu_out_en,
    output logic [2:0]             alu_op,
    output logic [NREG+NPORT-1:0]  reg_in,
    output logic [NREG+NPORT-1:0]  reg_out,
    output logic                   imm_out_en,
    output logic [DATA_W-1:0]      imm_data,
    output logic                   illegal,
    output logic                   timeout,
    output logic                   fetch_active
);
    localparam int NR = NREG + NPORT;
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    typedef enum logic [4:0] {
        RST_IDLE, FETCH0, FETCH1, FETCH2, DECODE,
        ALU_A, ALU_B, ALU_C, ALU_D,
        LD0, LD1, LD2, ST0, ST1, ST2,
        MOV0, MOVI0, JMP0, FAULT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    cls;
    logic [2:0]    dst, src;
    logic [NR-1:0] dst_oh, src_oh;
    logic          dst_ok, src_ok, bad, waiting;

    assign cls      = ir[15:12];
    assign dst      = ir[8:6];
    assign src      = ir[5:3];
    assign alu_op   = ir[11:9];
    assign imm_data = {{(DATA_W-6){ir[5]}}, ir[5:0]};
    assign dst_ok   = int'(dst) < NR;
    assign src_ok   = int'(src) < NR;

    always_comb begin
        dst_oh = '0;
        src_oh = '0;
        for (int i = 0; i < NR; i++) begin
            dst_oh[i] = (int'(dst) == i);
            src_oh[i] = (int'(src) == i);
        end
    end

    // Only the indices an instruction class actually uses are range-checked.
    always_comb begin
        case (cls)
            4'd0:                   bad = 1'b0;
            4'd1, 4'd3, 4'd4, 4'd5: bad = !dst_ok || !src_ok;
            4'd2, 4'd6:             bad = !dst_ok;
            4'd7, 4'd8:             bad = !src_ok;
            default:                bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = '0;
        waiting      = 1'b0;
        pc_out_en    = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        mar_in       = 1'b0;
        mdr_write_en = 1'b0;
        mdr_read_en  = 1'b0;
        mdr_out      = 1'b0;
        mem_en       = 1'b0;
        mem_rw       = 1'b0;
        ir_in        = 1'b0;
        alu_in0      = 1'b0;
        alu_in1      = 1'b0;
        alu_latch    = 1'b0;
        alu_out_en   = 1'b0;
        reg_in       = '0;
        reg_out      = '0;
        imm_out_en   = 1'b0;
        illegal      = 1'b0;
        timeout      = 1'b0;
        fetch_active = 1'b0;
        case (state)
            RST_IDLE: state_nxt = FETCH0;
            FETCH0: begin
                fetch_active = 1'b1;
                pc_out_en    = 1'b1;
                mar_in       = 1'b1;
                state_nxt    = FETCH1;
            end
            FETCH1: begin
                fetch_active = 1'b1;
                waiting      = 1'b1;
                mem_en       = 1'b1;
                mem_rw       = 1'b1;
                mdr_read_en  = mfc;
                if (mfc) state_nxt = FETCH2;
            end
            FETCH2: begin
                fetch_active = 1'b1;
                mdr_out      = 1'b1;
                ir_in        = 1'b1;
                pc_inc       = 1'b1;
                state_nxt    = DECODE;
            end
            DECODE: begin
                state_nxt = FETCH0;
                if (bad) illegal = 1'b1;
                else begin
                    case (cls)
                        4'd1, 4'd2: state_nxt = ALU_A;
                        4'd3:       state_nxt = LD0;
                        4'd4:       state_nxt = ST0;
                        4'd5:       state_nxt = MOV0;
                        4'd6:       state_nxt = MOVI0;
                        4'd7:       state_nxt = JMP0;
                        4'd8:       state_nxt = z_flag ? JMP0 : FETCH0;
                        default:    state_nxt = FETCH0;
                    endcase
                end
            end
            ALU_A: begin
                reg_out   = dst_oh;
                alu_in0   = 1'b1;
                state_nxt = ALU_B;
            end
            ALU_B: begin
                if (cls == 4'd2) imm_out_en = 1'b1;
                else             reg_out    = src_oh;
                alu_in1   = 1'b1;
                state_nxt = ALU_C;
            end
            ALU_C: begin
                alu_latch = 1'b1;
                state_nxt = ALU_D;
            end
            ALU_D: begin
                alu_out_en = 1'b1;
                reg_in     = dst_oh;
                state_nxt  = FETCH0;
            end
            LD0: begin
                reg_out   = src_oh;
                mar_in    = 1'b1;
                state_nxt = LD1;
            end
            LD1: begin
                waiting     = 1'b1;
                mem_en      = 1'b1;
                mem_rw      = 1'b1;
                mdr_read_en = mfc;
                if (mfc) state_nxt = LD2;
            end
            LD2: begin
                mdr_out   = 1'b1;
                reg_in    = dst_oh;
                state_nxt = FETCH0;
            end
            ST0: begin
                reg_out   = src_oh;
                mar_in    = 1'b1;
                state_nxt = ST1;
            end
            ST1: begin
                reg_out      = dst_oh;
                mdr_write_en = 1'b1;
                state_nxt    = ST2;
            end
            ST2: begin
                waiting = 1'b1;
                mem_en  = 1'b1;
                if (mfc) state_nxt = FETCH0;
            end
            MOV0: begin
                reg_out   = src_oh;
                reg_in    = dst_oh;
                state_nxt = FETCH0;
            end
            MOVI0: begin
                imm_out_en = 1'b1;
                reg_in     = dst_oh;
                state_nxt  = FETCH0;
            end
            JMP0: begin
                reg_out   = src_oh;
                pc_load   = 1'b1;
                state_nxt = FETCH0;
            end
            FAULT:   timeout = 1'b1;
            default: state_nxt = RST_IDLE;
        endcase
        // Shared wait-state timer: counts mfc-low cycles, trips into the sticky fault.
        if (waiting && !mfc) begin
            if (cnt == CNT_LAST) state_nxt = FAULT;
            else                 cnt_nxt   = cnt + CW'(1);
        end
    end
endmodule
